mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single unified instruction/data memory between two requesters: the CPU controller path (fetch, LDA, STO) and a DMA/program-loader port.
- Sequences each access through a fixed-latency memory cycle and returns read data and a completion pulse to the winner.
- Sits between controller/datapath and the memory array. Replaces the direct controller-to-memory connection.

Parameters:
- AW, 5, address width (matches CPU address bus)
- DW, 8, data width
- MEM_LAT, 2, memory access cycles per transaction (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held high until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted
- cpu_done  out  1  one-cycle pulse: CPU access complete
- cpu_rdata  out  DW  CPU read data, valid when cpu_done = 1, held until the next CPU read completes
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata: same as the cpu_* ports, for the DMA port
- mem_en  out  1  memory enable, high for the whole access
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid in the last access cycle
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, last_owner = DMA, lat_cnt = 0.
  - All gnt/done/mem_en/mem_we/busy = 0.
  - mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0.
- Reset asserted mid-access aborts the access immediately. No done pulse is issued.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Sample cpu_req and dma_req.
  - One request active: grant it.
  - Both active: grant the requester that is not last_owner (round-robin). The first contention after reset goes to the CPU.
  - On grant:
    - Pulse the winner's gnt for 1 cycle.
    - Latch owner, we, addr and wdata into internal registers.
    - Set last_owner = winner, lat_cnt = MEM_LAT-1.
    - Go to ACCESS.
  - No request: stay in IDLE; all mem_* strobes = 0.
- ACCESS:
  - mem_en = 1; mem_we = latched we; mem_addr/mem_wdata driven from the latched registers, stable for all MEM_LAT cycles.
  - lat_cnt decrements each cycle.
  - In the cycle where lat_cnt = 0, the owner's rdata register captures mem_rdata (reads only), then go to DONE.
- DONE:
  - Owner's done = 1 for exactly this cycle; mem_en = 0.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle T → gnt at T+1 → mem_en for cycles T+1..T+MEM_LAT → done at T+MEM_LAT+1.
- Back-to-back throughput: one transaction per MEM_LAT+2 cycles.
- Request handling rules:
  - Requesters drop req in the cycle after done. A req still high in IDLE is treated as a new transaction.
  - Requester inputs (we/addr/wdata/req) changing during ACCESS are ignored; the in-flight access completes with latched values.
  - A req withdrawn before grant is simply not served.
- Write transactions leave the owner's rdata unchanged.
- The non-owner's gnt/done stay 0 throughout the transaction.
- Round-robin fairness: under continuous contention, grants alternate CPU, DMA, CPU, DMA, ...

Test Plan:
- Reset: hold rst = 0, then release with no requests → busy = 0, all strobes 0, state IDLE for 20 cycles.
- CPU read: MEM_LAT = 2, mem returns 8'hA5 at addr 5'h03, cpu_req = 1, cpu_we = 0, cpu_addr = 5'h03 at T:
  - cpu_gnt at T+1.
  - mem_en = 1 at T+1 and T+2 with mem_addr = 5'h03.
  - cpu_done = 1 and cpu_rdata = 8'hA5 at T+3.
  - dma_gnt and dma_done stay 0.
- DMA write: dma_we = 1, dma_addr = 5'h1F, dma_wdata = 8'h3C → mem_we = 1 with addr 5'h1F / data 8'h3C for 2 cycles; dma_done pulse; cpu_rdata/dma_rdata unchanged.
- Contention: cpu_req and dma_req both held high for 4 transactions after reset → grant order CPU, DMA, CPU, DMA; each done is 4 cycles after the previous one.
- Input change mid-access: change cpu_addr from 5'h02 to 5'h07 during ACCESS → mem_addr stays 5'h02 until done.
- Reset mid-access: assert rst = 0 in the second ACCESS cycle → mem_en = 0 and busy = 0 immediately, no cpu_done. After release, the first contention is granted to the CPU.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the unified instruction/data memory: CPU controller vs DMA/loader.
// Round-robin on contention, fixed MEM_LAT-cycle access, registered gnt/done pulses and rdata.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t          state, state_next;
  owner_t          owner, last_owner, winner;
  logic [3:0]      lat_cnt;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic            grant;
  logic            last_beat;

  // Round-robin pick; the result only matters when at least one request is up.
  function automatic owner_t pick_owner(input logic c_req, input logic d_req,
                                        input owner_t last);
    if (c_req && d_req)
      return (last == OWN_CPU) ? OWN_DMA : OWN_CPU;
    return d_req ? OWN_DMA : OWN_CPU;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    winner     = OWN_CPU;
    last_beat  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant      = 1'b1;
          winner     = pick_owner(cpu_req, dma_req, last_owner);
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt == 4'd0) begin
          last_beat  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = (state == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);

  // Transaction registers: latched at grant so requester inputs are ignored mid-access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= OWN_CPU;
      last_owner <= OWN_DMA;
      lat_cnt    <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else if (grant) begin
      owner      <= winner;
      last_owner <= winner;
      lat_cnt    <= LAT_INIT;
      if (winner == OWN_DMA) begin
        we_q    <= dma_we;
        addr_q  <= dma_addr;
        wdata_q <= dma_wdata;
      end else begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end
    end else if (state == ACCESS && lat_cnt != 4'd0) begin
      lat_cnt <= lat_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_gnt  <= 1'b0;
      dma_gnt  <= 1'b0;
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      cpu_gnt  <= grant && (winner == OWN_CPU);
      dma_gnt  <= grant && (winner == OWN_DMA);
      cpu_done <= last_beat && (owner == OWN_CPU);
      dma_done <= last_beat && (owner == OWN_DMA);
    end
  end

  // Read data is captured on the final access beat and held until the next read by that port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else if (last_beat && !we_q) begin
      if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
      else                  dma_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected completions, a monitor checks each done pulse.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic       clk;
  logic       rst;
  logic       cpu_req, cpu_we, dma_req, dma_we;
  logic [4:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata, cpu_rdata, dma_rdata;
  logic       cpu_gnt, cpu_done, dma_gnt, dma_done, mem_en, mem_we, busy;

  mem_arbiter #(.AW(5), .DW(8), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    bit         dma;
    logic [7:0] ecpu;
    logic [7:0] edma;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory array model with a fixed initial image.
  logic [7:0] mem [32];
  bit         loaded;
  function automatic logic [7:0] image(input int a);
    case (a)
      2:       return 8'h5A;
      3:       return 8'hA5;
      5:       return 8'h11;
      7:       return 8'h77;
      default: return 8'h00;
    endcase
  endfunction
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= image(i);
      loaded <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected completion.
  exp_t e;
  always @(negedge clk) begin
    if (cpu_done || dma_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {30'd0, cpu_done, dma_done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_port", {30'd0, cpu_done, dma_done}, e.dma ? 32'd1 : 32'd2);
        check("done_cycle", cyc, e.cyc);
        check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e.ecpu});
        check("dma_rdata", {24'd0, dma_rdata}, {24'd0, e.edma});
      end
    end
  end

  task automatic push_exp(input bit dma, input logic [7:0] ecpu, input logic [7:0] edma,
                          input int at);
    exp_t x;
    x.dma = dma; x.ecpu = ecpu; x.edma = edma; x.cyc = at;
    sb.push_back(x);
  endtask

  task automatic single(input bit dma, input bit we, input logic [4:0] addr,
                        input logic [4:0] addr2, input logic [7:0] wd,
                        input logic [7:0] ecpu, input logic [7:0] edma);
    int k;
    @(posedge clk); #1;
    k = cyc;
    push_exp(dma, ecpu, edma, k + 3);
    if (dma) begin dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wd; end
    else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        check("gnt", {30'd0, cpu_gnt, dma_gnt}, dma ? 32'd1 : 32'd2);
        if (dma) dma_addr = addr2; else cpu_addr = addr2;
      end else begin
        check("gnt_pulse", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
      end
      check("mem_en", {31'd0, mem_en}, 32'd1);
      check("mem_we", {31'd0, mem_we}, {31'd0, we});
      check("mem_addr", {27'd0, mem_addr}, {27'd0, addr});
      if (we) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, wd});
    end
    @(posedge clk); #1;
    check("en_off_done", {30'd0, mem_en, busy}, 32'd1);
    cpu_req = 0; dma_req = 0;
  endtask

  initial begin
    int k;
    int ndma;
    rst = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_strobes", {25'd0, busy, mem_en, mem_we, cpu_gnt, cpu_done, dma_gnt, dma_done}, 32'd0);
    end
    check("reset_regs", {mem_addr, mem_wdata, cpu_rdata, dma_rdata}, 29'd0);

    single(0, 0, 5'h03, 5'h03, 8'h00, 8'hA5, 8'h00);
    single(1, 1, 5'h1F, 5'h1F, 8'h3C, 8'hA5, 8'h00);
    check("mem_written", {24'd0, mem[31]}, 32'h3C);
    single(0, 0, 5'h02, 5'h07, 8'h00, 8'h5A, 8'h00);
    single(1, 0, 5'h1F, 5'h1F, 8'h00, 8'h5A, 8'h3C);

    // Reset in the second access cycle aborts the transaction
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h03;
    @(posedge clk); #1;
    check("abort_gnt", {31'd0, cpu_gnt}, 32'd1);
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("abort_en_busy", {30'd0, mem_en, busy}, 32'd0);
    check("abort_done", {30'd0, cpu_done, dma_done}, 32'd0);
    cpu_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;

    // Continuous contention: CPU first, then alternate
    @(posedge clk); #1;
    k = cyc;
    push_exp(0, 8'hA5, 8'h00, k + 3);
    push_exp(1, 8'hA5, 8'h11, k + 7);
    push_exp(0, 8'hA5, 8'h11, k + 11);
    push_exp(1, 8'hA5, 8'h11, k + 15);
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h03;
    dma_req = 1; dma_we = 0; dma_addr = 5'h05;
    ndma = 0;
    for (int i = 0; i < 30 && ndma < 2; i++) begin
      @(posedge clk); #1;
      if (dma_done) ndma++;
    end
    cpu_req = 0; dma_req = 0;
    check("contention_finished", ndma, 2);

    repeat (6) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    check("final_idle", {31'd0, busy}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
